// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes and mux selects.
// MULTICYCLE_CTRL_MEM_WAIT_EN adds the memory wait states FETCHW and MEMREADW.
`timescale 1ns/1ps
package riscv_ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_EXECU,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR1,
        S_JALR2,
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        S_FETCHW,
        S_MEMREADW,
`endif
        S_HALT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Immediate format implied by the opcode; R-type and unknown opcodes fall back to I.
    function automatic logic [2:0] imm_src(input logic [6:0] i_op);
        logic [2:0] r_imm;
        case (i_op)
            OP_STORE:        r_imm = IMM_S;
            OP_BRANCH:       r_imm = IMM_B;
            OP_JAL:          r_imm = IMM_J;
            OP_LUI, OP_AUIPC: r_imm = IMM_U;
            default:         r_imm = IMM_I;
        endcase
        return r_imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from ALUOp and the instruction function fields.
`timescale 1ns/1ps
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op[5]=1) can encode sub; addi ignores Instr[30].
                    3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core; drives every datapath enable and mux select.
// MULTICYCLE_CTRL_MEM_WAIT_EN inserts FETCHW/MEMREADW for block-RAM read latency.
`timescale 1ns/1ps
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
)
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       halted
);

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    localparam state_t FETCH_ENTRY = S_FETCHW;
    localparam state_t READ_ENTRY  = S_MEMREADW;
`else
    localparam state_t FETCH_ENTRY = S_FETCH;
    localparam state_t READ_ENTRY  = S_MEMREAD;
`endif

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_alu_op;
    logic       w_pcwrite;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= FETCH_ENTRY;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_LUI, OP_AUIPC:  w_next = S_EXECU;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR1;
                    default:           w_next = HALT_ON_ILLEGAL ? S_HALT : FETCH_ENTRY;
                endcase
            end
            S_MEMADR:  w_next = op[5] ? S_MEMWRITE : READ_ENTRY;
            S_MEMREAD: w_next = S_MEMWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: w_next = FETCH_ENTRY;
            S_EXECR, S_EXECI, S_EXECU, S_JAL, S_JALR2: w_next = S_ALUWB;
            S_JALR1:   w_next = S_JALR2;
            S_HALT:    w_next = S_HALT;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
            S_FETCHW:   w_next = S_FETCH;
            S_MEMREADW: w_next = S_MEMREAD;
`endif
            default:   w_next = FETCH_ENTRY;
        endcase
    end

    always_comb begin
        w_pcwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        w_alu_op   = ALUOP_ADD;
        ImmSrc     = imm_src(op);
        case (r_state)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ImmSrc    = IMM_I;
            end
            // ALUOut captures OldPC+Imm here so BRANCH/JAL find their target ready.
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR, S_JALR1: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                w_regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA  = SRCA_RS1;
                w_alu_op = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
            end
            S_EXECU: begin
                ALUSrcA = op[5] ? SRCA_ZERO : SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_ALUWB: w_regwrite = 1'b1;
            // beq/bne differ only in funct3[0]; Zero feeds PCWrite without a register.
            S_BRANCH: begin
                ALUSrcA   = SRCA_RS1;
                w_alu_op  = ALUOP_SUB;
                w_pcwrite = Zero ^ funct3[0];
            end
            S_JAL, S_JALR2: begin
                w_pcwrite = 1'b1;
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
            end
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
            S_FETCHW:   ImmSrc = IMM_I;
            S_MEMREADW: AdrSrc = 1'b1;
`endif
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (w_alu_op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .ALUControl (ALUControl)
    );

    // Enables drop the moment resetn falls, even mid-cycle.
    assign PCWrite  = w_pcwrite  & resetn;
    assign IRWrite  = w_irwrite  & resetn;
    assign RegWrite = w_regwrite & resetn;
    assign MemWrite = w_memwrite & resetn;
    assign halted   = (r_state == S_HALT);

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RV32I datapath. Decodes `op`/`funct3`/`funct7b5` from the instruction register and drives every datapath enable and mux select, one state per clock, sequencing fetch, decode, execute, memory and writeback. Sits beside `datapath` in the core top level and is the only source of its control inputs.

## Interface
- `HALT_ON_ILLEGAL`, default 1: 1 = an unknown opcode parks the FSM in HALT; 0 = an unknown opcode retires as a NOP and returns to FETCH.
- `clk` in 1: core clock, the same `clk` as the datapath.
- `resetn` in 1: asynchronous active-low reset.
- `op` in 7: Instr[6:0].
- `funct3` in 3: Instr[14:12].
- `funct7b5` in 1: Instr[30].
- `Zero` in 1: ALU zero flag.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = Result.
- `MemWrite` out 1: memory write enable.
- `IRWrite` out 1: instruction/OldPC register enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: result mux select; 00 = ALUOut, 01 = data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A select; 00 = PC, 01 = OldPC, 10 = rs1 register, 11 = zero.
- `ALUSrcB` out 2: ALU B select; 00 = rs2 register, 01 = ImmExt, 10 = 4.
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- `ImmSrc` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `halted` out 1: high while in HALT.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, EXECU, ALUWB, BRANCH, JAL, JALR1, JALR2, HALT.
- Unlisted outputs in each state are 0 / 00 / add.
- FETCH: AdrSrc=0, IRWrite=1, A=PC, B=4, add, ResultSrc=10, PCWrite=1. Always goes to DECODE.
- DECODE: A=OldPC, B=Imm, add, so ALUOut holds the branch/jal target. ImmSrc follows `op` from this state onward.
- DECODE next state by opcode:
  - 0000011 (lw) and 0100011 (sw) -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 0110111 and 0010111 -> EXECU.
  - 1100011 -> BRANCH.
  - 1101111 -> JAL.
  - 1100111 -> JALR1.
  - Any other opcode -> HALT, or FETCH when HALT_ON_ILLEGAL=0.
- MEMADR: A=rs1, B=Imm, add. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 -> FETCH.
- EXECR: A=rs1, B=rs2, ALUOp=funct -> ALUWB.
- EXECI: A=rs1, B=Imm, ALUOp=funct -> ALUWB.
- EXECU: B=Imm, add; A=zero for lui (op[5]=1), A=OldPC for auipc -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BRANCH: A=rs1, B=rs2, sub, ResultSrc=00. PCWrite = Zero XOR funct3[0] (beq/bne) -> FETCH.
- JAL: ResultSrc=00, PCWrite=1, A=OldPC, B=4, add -> ALUWB. This writes the link value PC+4.
- JALR1: A=rs1, B=Imm, add -> JALR2.
- JALR2: ResultSrc=00, PCWrite=1, A=OldPC, B=4 -> ALUWB.
- HALT: all enables 0, `halted`=1. Only reset leaves HALT.
- ALU decode (ALUOp add / sub / funct):
  - funct3 000: sub iff op[5]&funct7b5, else add.
  - 010: slt. 100: xor. 110: or. 111: and.
  - Any other funct3: add.

## Timing
- `resetn` low forces state FETCH asynchronously. While `resetn` is low, PCWrite, IRWrite, RegWrite and MemWrite are 0 and `halted` is 0.
- First FETCH is the first rising edge after `resetn` deasserts.
- All outputs are combinational from state, `op`, `funct3` and `funct7b5`. PCWrite in BRANCH is additionally combinational from `Zero`, Mealy style.
- Cycles per instruction (wait states off):
  - beq/bne: 3.
  - R-type, I-ALU, lui/auipc, sw, jal: 4.
  - lw, jalr: 5.
- `op` is stable from DECODE to retirement; IRWrite is asserted only in FETCH.
- Reset mid-instruction abandons it. A write enable already asserted in that cycle is cut when `resetn` falls.

## Configuration
- `MULTICYCLE_CTRL_MEM_WAIT_EN` defined:
  - Adds FETCHW before FETCH: AdrSrc=0, no enables. Reset and every return-to-fetch go to FETCHW.
  - Adds MEMREADW before MEMREAD: AdrSrc=1, ResultSrc=00. Covers one cycle of block-RAM read latency.
  - Every instruction gains 1 cycle; lw gains 2.
- Undefined: the state graph is exactly as above.

## Structure
- `riscv_ctrl_pkg` holds:
  - state enum;
  - opcode constants;
  - ALUControl, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings;
  - ALUOp encoding.
- One sub-module, `alu_decoder`, maps (ALUOp, funct3, funct7b5, op[5]) to ALUControl. It is purely combinational.

## Test plan
- Reset then release: first cycle is FETCH, with PCWrite=1, IRWrite=1, ALUSrcB=10, ResultSrc=10; DECODE follows.
- add vs sub: op=0110011, funct3=000, funct7b5=1 gives sub (001) in EXECR, RegWrite=1 in ALUWB, FETCH after 4 cycles. With funct7b5=0 it gives add (000).
- lw / sw: op=0000011 gives MEMREAD (AdrSrc=1), then MEMWB with ResultSrc=01 and RegWrite=1, 5 cycles total. op=0100011 gives MemWrite=1 exactly one cycle.
- beq / bne: beq with Zero=1 gives PCWrite=1 in BRANCH. beq with Zero=0 gives PCWrite=0. bne with Zero=0 gives PCWrite=1.
- jalr: JALR1 then JALR2 (PCWrite=1, ResultSrc=00), then ALUWB with RegWrite=1.
- Illegal op=1111111: `halted`=1 and no enables for 100 cycles. With HALT_ON_ILLEGAL=0 it returns to FETCH after DECODE. With the macro defined, lw takes 7 cycles.
